master_slave_jk_flip_flop: RTL and testbench

//  Edge-triggered master-slave JK flip-flop (bank of WIDTH independent bits).
//  - Master stage samples J/K on the clk rising edge.
//  - Slave stage transfers master to Q on the following clk falling edge.
//  - Used as a basic sequential building block (counters, toggle registers).
//  - WIDTH=1 reproduces the classic single-bit JK master-slave cell.

---
 rtl/master_slave_jk_flip_flop.sv | 20 ++
 tb/tb_master_slave_jk_flip_flop.sv | 87 ++++++++
 2 files changed

// File: rtl/master_slave_jk_flip_flop.sv
// master_slave_jk_flip_flop: bank of WIDTH independent master-slave JK flip-flops
// Ports: clk (master captures on rise, slave on fall), reset (sync, active-high, clears master),
//        J/K per-bit JK inputs, Q slave-stage registered output.
module master_slave_jk_flip_flop #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q
);
  logic [WIDTH-1:0] m_q, m_d, q_q;
  // JK characteristic equation, evaluated against the slave output
  always_comb m_d = (J & ~q_q) | (~K & q_q);
  always_ff @(posedge clk) m_q <= reset ? '0 : m_d;
  // slave has no reset of its own; it picks up the cleared master on the falling edge
  always_ff @(negedge clk) q_q <= m_q;
  assign Q = q_q;
endmodule

// File: tb/tb_master_slave_jk_flip_flop.sv
// tb_master_slave_jk_flip_flop: scoreboard bench for 1-bit and 4-bit JK master-slave banks
module tb_master_slave_jk_flip_flop;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] j, k;
  logic [3:0] q4;
  logic       q1;
  int         n_cmp = 0;
  int         n_bad = 0;
  typedef struct {
    logic       r;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] e;
  } vec_t;
  vec_t       vecs[16];
  logic [3:0] exp_q[$];

  master_slave_jk_flip_flop #(.WIDTH(1)) u1 (.clk(clk), .reset(reset), .J(j[0]), .K(k[0]), .Q(q1));
  master_slave_jk_flip_flop #(.WIDTH(4)) u4 (.clk(clk), .reset(reset), .J(j), .K(k), .Q(q4));

  always #5 clk = ~clk;

  initial begin
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000};
    vecs[2]  = '{1'b0, 4'b1111, 4'b0000, 4'b1111};
    vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 4'b1111};
    vecs[4]  = '{1'b0, 4'b0000, 4'b1111, 4'b0000};
    vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000};
    vecs[6]  = '{1'b0, 4'b1111, 4'b1111, 4'b1111};
    vecs[7]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000};
    vecs[8]  = '{1'b0, 4'b1111, 4'b1111, 4'b1111};
    vecs[9]  = '{1'b1, 4'b1111, 4'b1111, 4'b0000};
    vecs[10] = '{1'b0, 4'b0101, 4'b0000, 4'b0101};
    vecs[11] = '{1'b0, 4'b0011, 4'b1010, 4'b0111};
    vecs[12] = '{1'b0, 4'b1010, 4'b0101, 4'b1010};
    vecs[13] = '{1'b0, 4'b1111, 4'b1111, 4'b0101};
    vecs[14] = '{1'b0, 4'b0110, 4'b1001, 4'b0110};
    vecs[15] = '{1'b1, 4'b1100, 4'b0011, 4'b0000};
    reset = 1'b1;
    j = '0;
    k = '0;
    for (int i = 0; i < 16; i++) begin
      reset = vecs[i].r;
      j = vecs[i].j;
      k = vecs[i].k;
      @(posedge clk);
      exp_q.push_back(vecs[i].e);
      #1;
      // scramble J/K between the sampling edge and the slave transfer
      j = 4'($urandom);
      k = 4'($urandom);
      @(negedge clk);
      #2;
    end
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses never observed, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (q4 !== e) begin
          n_bad++;
          $display("FAIL q4 @%0t: got %b, required %b", $time, q4, e);
        end
        n_cmp++;
        if (q1 !== e[0]) begin
          n_bad++;
          $display("FAIL q1 @%0t: got %b, required %b", $time, q1, e[0]);
        end
      end
    end
  end
endmodule
